ex_mem_reg: RTL and testbench

EX/MEM pipeline register of the 5-stage MIPS core. It captures the combined EX-stage result (shift, logic, arithmetic, HI/LO and load/store info) at the clock edge and presents it to MEM. It honours the global stall vector and flush, inserting bubbles where required. It also holds the intermediate 64-bit product and cycle counter for two-cycle MADD/MADDU/MSUB/MSUBU, feeding them back to EX.

---
 rtl/ex_mem_reg_pkg.sv | 69 ++++++
 rtl/ex_mem_reg_madd_hold.sv | 51 +++++
 rtl/ex_mem_reg.sv | 105 ++++++++++
 tb/tb_ex_mem_reg.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_reg_pkg.sv
`default_nettype none
//==============================================================================
// Module      : ex_mem_reg_pkg
// Description : Shared widths, constants, the EX/MEM payload type and the
//               stall/flush update decoder for the EX/MEM pipeline register.
// Revision    : 1.0 - initial release
//==============================================================================
package ex_mem_reg_pkg;

    localparam int REG_BUS        = 32;
    localparam int REG_ADDR_BUS   = 5;
    localparam int ALU_OP_BUS     = 8;
    localparam int DOUBLE_REG_BUS = 64;
    localparam int STALL_W        = 6;

    // Stall vector bit positions
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;

    localparam logic                  RST_ENABLE = 1'b1;
    localparam logic [ALU_OP_BUS-1:0] EXE_NOP_OP = 8'h00;
    localparam logic [REG_BUS-1:0]    ZERO_WORD  = 32'h0000_0000;

    // Everything EX hands to MEM, carried as one packed word
    typedef struct packed {
        logic [REG_ADDR_BUS-1:0] wd;
        logic                    wreg;
        logic [REG_BUS-1:0]      wdata;
        logic                    whilo;
        logic [REG_BUS-1:0]      hi;
        logic [REG_BUS-1:0]      lo;
        logic [ALU_OP_BUS-1:0]   aluop;
        logic [REG_BUS-1:0]      mem_addr;
        logic [REG_BUS-1:0]      reg2;
    } ex_mem_t;

    // An all-zero entry is a bubble: no writes, NOP opcode
    localparam ex_mem_t BUBBLE_ENTRY = '{
        wd: '0, wreg: 1'b0, wdata: ZERO_WORD, whilo: 1'b0,
        hi: ZERO_WORD, lo: ZERO_WORD, aluop: EXE_NOP_OP,
        mem_addr: ZERO_WORD, reg2: ZERO_WORD
    };

    typedef enum logic [1:0] {
        UPD_CLEAR   = 2'd0,
        UPD_BUBBLE  = 2'd1,
        UPD_ADVANCE = 2'd2,
        UPD_HOLD    = 2'd3
    } upd_e;

    // Flush beats stall. EX stalled with MEM running emits a bubble; EX running
    // advances (this also covers the never-produced MEM-only stall); both
    // stalled holds.
    function automatic upd_e stage_update(input logic               flush,
                                          input logic [STALL_W-1:0] stall);
        upd_e r;
        if (flush)
            r = UPD_CLEAR;
        else if (stall[STALL_EX] && !stall[STALL_MEM])
            r = UPD_BUBBLE;
        else if (!stall[STALL_EX])
            r = UPD_ADVANCE;
        else
            r = UPD_HOLD;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem_reg_madd_hold.sv
`default_nettype none
//==============================================================================
// Module      : madd_hold
// Description : Holds the intermediate 64-bit MADD/MSUB product and its cycle
//               counter while EX is stalled, feeding them back to EX. Built
//               only when EX_MEM_MADD_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`ifdef EX_MEM_MADD_EN
module madd_hold
    import ex_mem_reg_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  upd_e                      upd_i,
    input  logic [DOUBLE_REG_BUS-1:0] hilo_i,
    input  logic [1:0]                cnt_i,
    output logic [DOUBLE_REG_BUS-1:0] hilo_o,
    output logic [1:0]                cnt_o
);

    logic [DOUBLE_REG_BUS-1:0] hilo_d, hilo_q;
    logic [1:0]                cnt_d,  cnt_q;

    // Keep the partial product only while EX is stalled; any flush or advance drops it
    always_comb begin
        hilo_d = '0;
        cnt_d  = 2'd0;
        if (upd_i == UPD_BUBBLE || upd_i == UPD_HOLD) begin
            hilo_d = hilo_i;
            cnt_d  = cnt_i;
        end
    end

    // Holding register, cleared by reset
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            hilo_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            hilo_q <= hilo_d;
            cnt_q  <= cnt_d;
        end
    end

    assign hilo_o = hilo_q;
    assign cnt_o  = cnt_q;

endmodule
`endif
`default_nettype wire

// File: rtl/ex_mem_reg.sv
`default_nettype none
//==============================================================================
// Module      : ex_mem_reg
// Description : EX/MEM pipeline register. Captures the EX result each edge,
//               honouring flush and the global stall vector (bubble / hold),
//               and optionally holds the two-cycle MADD/MSUB intermediate.
//               Optional feature macro: EX_MEM_MADD_EN.
// Revision    : 1.0 - initial release
//==============================================================================
module ex_mem_reg
    import ex_mem_reg_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STALL_W-1:0]        stall,
    input  logic                      flush,
    input  logic [REG_ADDR_BUS-1:0]   ex_wd,
    input  logic                      ex_wreg,
    input  logic [REG_BUS-1:0]        ex_wdata,
    input  logic                      ex_whilo,
    input  logic [REG_BUS-1:0]        ex_hi,
    input  logic [REG_BUS-1:0]        ex_lo,
    input  logic [ALU_OP_BUS-1:0]     ex_aluop,
    input  logic [REG_BUS-1:0]        ex_mem_addr,
    input  logic [REG_BUS-1:0]        ex_reg2,
    input  logic [DOUBLE_REG_BUS-1:0] hilo_i,
    input  logic [1:0]                cnt_i,
    output logic [REG_ADDR_BUS-1:0]   mem_wd,
    output logic                      mem_wreg,
    output logic [REG_BUS-1:0]        mem_wdata,
    output logic                      mem_whilo,
    output logic [REG_BUS-1:0]        mem_hi,
    output logic [REG_BUS-1:0]        mem_lo,
    output logic [ALU_OP_BUS-1:0]     mem_aluop,
    output logic [REG_BUS-1:0]        mem_mem_addr,
    output logic [REG_BUS-1:0]        mem_reg2,
    output logic [DOUBLE_REG_BUS-1:0] hilo_o,
    output logic [1:0]                cnt_o
);

    upd_e    w_upd;
    ex_mem_t w_ex;
    ex_mem_t pipe_d, pipe_q;

    // Only the EX and MEM stall bits matter to this stage
    logic w_unused_stall;
    assign w_unused_stall = ^{stall[STALL_W-1:STALL_MEM+1], stall[STALL_EX-1:0]};

    assign w_upd = stage_update(flush, stall);

    assign w_ex = '{
        wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata, whilo: ex_whilo,
        hi: ex_hi, lo: ex_lo, aluop: ex_aluop,
        mem_addr: ex_mem_addr, reg2: ex_reg2
    };

    // Next entry: clear/bubble insert a NOP, advance takes EX, hold keeps the current entry
    always_comb begin
        pipe_d = pipe_q;
        case (w_upd)
            UPD_CLEAR:   pipe_d = BUBBLE_ENTRY;
            UPD_BUBBLE:  pipe_d = BUBBLE_ENTRY;
            UPD_ADVANCE: pipe_d = w_ex;
            default:     pipe_d = pipe_q;
        endcase
    end

    // Pipeline register proper
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE)
            pipe_q <= BUBBLE_ENTRY;
        else
            pipe_q <= pipe_d;
    end

    assign mem_wd       = pipe_q.wd;
    assign mem_wreg     = pipe_q.wreg;
    assign mem_wdata    = pipe_q.wdata;
    assign mem_whilo    = pipe_q.whilo;
    assign mem_hi       = pipe_q.hi;
    assign mem_lo       = pipe_q.lo;
    assign mem_aluop    = pipe_q.aluop;
    assign mem_mem_addr = pipe_q.mem_addr;
    assign mem_reg2     = pipe_q.reg2;

`ifdef EX_MEM_MADD_EN
    madd_hold u_madd_hold (
        .clk    (clk),
        .rst    (rst),
        .upd_i  (w_upd),
        .hilo_i (hilo_i),
        .cnt_i  (cnt_i),
        .hilo_o (hilo_o),
        .cnt_o  (cnt_o)
    );
`else
    // Feature absent: feedback path tied off, EX intermediate ignored
    logic w_unused_madd;
    assign w_unused_madd = ^{hilo_i, cnt_i};
    assign hilo_o = '0;
    assign cnt_o  = 2'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_reg.sv
`default_nettype none
//==============================================================================
// Module      : tb_ex_mem_reg
// Description : Self-checking bench for ex_mem_reg: directed vector table plus
//               hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_ex_mem_reg;
    import ex_mem_reg_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    ex_mem_t     ex;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;

    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ex_mem_reg dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .ex_wd        (ex.wd),
        .ex_wreg      (ex.wreg),
        .ex_wdata     (ex.wdata),
        .ex_whilo     (ex.whilo),
        .ex_hi        (ex.hi),
        .ex_lo        (ex.lo),
        .ex_aluop     (ex.aluop),
        .ex_mem_addr  (ex.mem_addr),
        .ex_reg2      (ex.reg2),
        .hilo_i       (hilo_i),
        .cnt_i        (cnt_i),
        .mem_wd       (mem_wd),
        .mem_wreg     (mem_wreg),
        .mem_wdata    (mem_wdata),
        .mem_whilo    (mem_whilo),
        .mem_hi       (mem_hi),
        .mem_lo       (mem_lo),
        .mem_aluop    (mem_aluop),
        .mem_mem_addr (mem_mem_addr),
        .mem_reg2     (mem_reg2),
        .hilo_o       (hilo_o),
        .cnt_o        (cnt_o)
    );

    // Payload patterns: wd, wreg, wdata, whilo, hi, lo, aluop, mem_addr, reg2
    localparam ex_mem_t Z   = '0;
    localparam ex_mem_t PA  = '{5'd7, 1'b1, 32'hAAAA_AAAA, 1'b1, 32'h1, 32'h2, 8'h24, 32'h10, 32'h20};
    localparam ex_mem_t P1  = '{5'd5, 1'b1, 32'h0000_0100, 1'b1, 32'h11, 32'h22, 8'h24, 32'h1000, 32'h55};
    localparam ex_mem_t PB  = '{5'd9, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0, 8'h24, 32'h3000, 32'h66};
    localparam ex_mem_t P2  = '{5'd3, 1'b1, 32'h0000_1234, 1'b0, 32'h0, 32'h0, 8'h21, 32'h2000, 32'h77};
    localparam ex_mem_t PH  = '{5'd8, 1'b1, 32'h9999_9999, 1'b1, 32'h5, 32'h6, 8'h2B, 32'h4000, 32'h88};
    localparam ex_mem_t PM1 = '{5'd4, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 8'hA6, 32'h0, 32'h0};
    localparam ex_mem_t PM2 = '{5'd0, 1'b0, 32'h0, 1'b1, 32'h1, 32'h5, 8'hA6, 32'h0, 32'h0};
    localparam ex_mem_t PF  = '{5'h1F, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'hFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    localparam ex_mem_t P3  = '{5'd2, 1'b1, 32'h0000_0042, 1'b0, 32'h0, 32'h0, 8'h20, 32'h8, 32'h9};

    typedef struct {
        logic        rst;
        logic        flush;
        logic [5:0]  stall;
        ex_mem_t     ex;
        logic [63:0] hilo_i;
        logic [1:0]  cnt_i;
        ex_mem_t     e_mem;
        logic [63:0] e_hilo;   // expected with the MADD holding register built
        logic [1:0]  e_cnt;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input ex_mem_t e, input logic [63:0] eh, input logic [1:0] ec);
        logic [63:0] xh;
        logic [1:0]  xc;
`ifdef EX_MEM_MADD_EN
        xh = eh;
        xc = ec;
`else
        xh = 64'd0;
        xc = 2'd0;
`endif
        chk("wd",       idx, 64'(mem_wd),       64'(e.wd));
        chk("wreg",     idx, 64'(mem_wreg),     64'(e.wreg));
        chk("wdata",    idx, 64'(mem_wdata),    64'(e.wdata));
        chk("whilo",    idx, 64'(mem_whilo),    64'(e.whilo));
        chk("hi",       idx, 64'(mem_hi),       64'(e.hi));
        chk("lo",       idx, 64'(mem_lo),       64'(e.lo));
        chk("aluop",    idx, 64'(mem_aluop),    64'(e.aluop));
        chk("mem_addr", idx, 64'(mem_mem_addr), 64'(e.mem_addr));
        chk("reg2",     idx, 64'(mem_reg2),     64'(e.reg2));
        chk("hilo_o",   idx, hilo_o,            xh);
        chk("cnt_o",    idx, 64'(cnt_o),        64'(xc));
    endtask

    task automatic drive(input logic r, input logic f, input logic [5:0] s,
                         input ex_mem_t e, input logic [63:0] h, input logic [1:0] c);
        rst    = r;
        flush  = f;
        stall  = s;
        ex     = e;
        hilo_i = h;
        cnt_i  = c;
    endtask

    initial begin
        //          rst   flush stall      ex   hilo_i                 cnt    e_mem e_hilo                 e_cnt
        tbl[0]  = '{1'b1, 1'b0, 6'b001111, PA,  64'h5,                 2'd1,  Z,    64'h0,                 2'd0}; // reset
        tbl[1]  = '{1'b0, 1'b0, 6'b000000, P1,  64'hFF,                2'd2,  P1,   64'h0,                 2'd0}; // advance
        tbl[2]  = '{1'b0, 1'b0, 6'b001111, PB,  64'h0000_0003_0000_0004, 2'd1, Z,   64'h0000_0003_0000_0004, 2'd1}; // bubble
        tbl[3]  = '{1'b0, 1'b0, 6'b000000, P2,  64'h0,                 2'd0,  P2,   64'h0,                 2'd0}; // load 0x1234
        tbl[4]  = '{1'b0, 1'b0, 6'b011111, PH,  64'h10,                2'd1,  P2,   64'h10,                2'd1}; // hold 1
        tbl[5]  = '{1'b0, 1'b0, 6'b011111, PH,  64'h11,                2'd2,  P2,   64'h11,                2'd2}; // hold 2
        tbl[6]  = '{1'b0, 1'b0, 6'b011111, PA,  64'h12,                2'd3,  P2,   64'h12,                2'd3}; // hold 3
        tbl[7]  = '{1'b0, 1'b0, 6'b001111, PM1, 64'h0000_0001_0000_0002, 2'd1, Z,   64'h0000_0001_0000_0002, 2'd1}; // MADD c1
        tbl[8]  = '{1'b0, 1'b0, 6'b000000, PM2, 64'h0,                 2'd2,  PM2,  64'h0,                 2'd0}; // MADD c2
        tbl[9]  = '{1'b0, 1'b1, 6'b011111, PH,  64'h77,                2'd1,  Z,    64'h0,                 2'd0}; // flush over hold
        tbl[10] = '{1'b0, 1'b0, 6'b000000, PF,  64'hFFFF_FFFF_FFFF_FFFF, 2'd3, PF,  64'h0,                 2'd0}; // all ones
        tbl[11] = '{1'b0, 1'b0, 6'b010000, P3,  64'h99,                2'd1,  P3,   64'h0,                 2'd0}; // MEM-only stall -> advance
        tbl[12] = '{1'b0, 1'b0, 6'b001111, PB,  64'hCAFE_F00D_1234_5678, 2'd1, Z,   64'hCAFE_F00D_1234_5678, 2'd1}; // MADD c1
        tbl[13] = '{1'b1, 1'b0, 6'b001111, PH,  64'hABCD,              2'd1,  Z,    64'h0,                 2'd0}; // reset mid-MADD
        tbl[14] = '{1'b0, 1'b1, 6'b001111, PH,  64'h1357,              2'd1,  Z,    64'h0,                 2'd0}; // flush over bubble
        tbl[15] = '{1'b0, 1'b0, 6'b011111, PH,  64'h2468,              2'd2,  Z,    64'h2468,              2'd2}; // hold of empty entry
        tbl[16] = '{1'b0, 1'b0, 6'b100111, P1,  64'h3,                 2'd1,  P1,   64'h0,                 2'd0}; // other stall bits ignored

        drive(1'b1, 1'b0, 6'b0, Z, 64'h0, 2'd0);
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].flush, tbl[i].stall, tbl[i].ex, tbl[i].hilo_i, tbl[i].cnt_i);
            @(posedge clk);
            #1;
            chk_all(i, tbl[i].e_mem, tbl[i].e_hilo, tbl[i].e_cnt);
        end

        // No combinational path: changing EX between edges leaves the outputs alone
        @(negedge clk);
        drive(1'b0, 1'b0, 6'b000000, PF, 64'h77, 2'd1);
        #1;
        chk_all(100, P1, 64'h0, 2'd0);
        @(posedge clk);
        #1;
        chk_all(101, PF, 64'h0, 2'd0);

        // Two-cycle MADD interrupted by a hold then completed
        @(negedge clk);
        drive(1'b0, 1'b0, 6'b001111, PM1, 64'h0000_0002_0000_0003, 2'd1);
        @(posedge clk);
        #1;
        chk_all(102, Z, 64'h0000_0002_0000_0003, 2'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 6'b011111, PM1, 64'h0000_0002_0000_0003, 2'd1);
        @(posedge clk);
        #1;
        chk_all(103, Z, 64'h0000_0002_0000_0003, 2'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 6'b000000, PM2, 64'h0, 2'd2);
        @(posedge clk);
        #1;
        chk_all(104, PM2, 64'h0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
